// File: rtl/i_cache_line_if.sv
// CPU-fetch and memory-read signal bundle for i_cache_line.
// master: the side that drives fetch requests and memory responses (CPU + memory).
// slave:  the cache itself.
interface i_cache_line_if;
    logic [31:0] p_a;
    logic        p_strobe;
    logic        uncached;
    logic        inv;
    logic [31:0] p_din;
    logic        p_ready;
    logic        cache_miss;
    logic [31:0] m_a;
    logic        m_strobe;
    logic [31:0] m_dout;
    logic        m_ready;

    modport master (
        output p_a, p_strobe, uncached, inv, m_dout, m_ready,
        input  p_din, p_ready, cache_miss, m_a, m_strobe
    );

    modport slave (
        input  p_a, p_strobe, uncached, inv, m_dout, m_ready,
        output p_din, p_ready, cache_miss, m_a, m_strobe
    );
endinterface

// File: rtl/i_cache_line.sv
// Direct-mapped instruction cache with multi-word lines and a sequential
// line-refill FSM. Hits return combinationally; a cached miss refills the
// whole line one word per memory beat, then the request hits. Uncached
// fetches bypass the array. inv clears every valid bit (and aborts a refill).
// Optional hit/miss statistics counters: define ICACHE_STATS_EN.
module i_cache_line #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2
) (
    input  logic               clk,
    input  logic               clrn,
    i_cache_line_if.slave      bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state;
    logic [TAG_BITS-1:0]     fill_tag;
    logic [INDEX_BITS-1:0]   fill_index;
    logic [OFFSET_BITS-1:0]  word_cnt;
    logic [LINES-1:0]        valid;

    logic [TAG_BITS-1:0]     tag_mem  [LINES];
    logic [31:0]             data_mem [LINES*WORDS];

    // Address split of the incoming fetch.
    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   req_index;
    logic [OFFSET_BITS-1:0]  req_off;
    logic                    unused_low;

    assign req_tag    = bus.p_a[31 -: TAG_BITS];
    assign req_index  = bus.p_a[2+OFFSET_BITS +: INDEX_BITS];
    assign req_off    = bus.p_a[2 +: OFFSET_BITS];
    assign unused_low = ^bus.p_a[1:0];

    logic hit;
    logic array_hit;
    logic start_fill;
    logic fill_beat;
    logic last_beat;

    assign hit        = bus.p_strobe & ~bus.uncached & valid[req_index]
                        & (tag_mem[req_index] == req_tag);
    assign array_hit  = (state == IDLE) & hit;
    assign start_fill = (state == IDLE) & bus.p_strobe & ~bus.uncached & ~hit;
    // A beat that coincides with inv is dropped: the invalidate wins.
    assign fill_beat  = (state == FILL) & bus.m_ready & ~bus.inv;
    assign last_beat  = fill_beat & (word_cnt == '1);

    // Combinational CPU and memory outputs, selected by state and request type.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch); always_comb uses blocking '=' only.
    always_comb begin
        bus.p_ready    = 1'b0;
        bus.p_din      = data_mem[{req_index, req_off}];
        bus.cache_miss = 1'b0;
        bus.m_strobe   = 1'b0;
        bus.m_a        = bus.p_a;
        if (state == FILL) begin
            bus.m_strobe   = 1'b1;
            bus.cache_miss = 1'b1;
            bus.m_a        = {fill_tag, fill_index, word_cnt, 2'b00};
        end else if (bus.p_strobe) begin
            if (bus.uncached) begin
                bus.cache_miss = 1'b1;
                bus.m_strobe   = 1'b1;
                bus.p_ready    = bus.m_ready;
                bus.p_din      = bus.m_dout;
            end else if (hit) begin
                bus.p_ready    = 1'b1;
            end else begin
                bus.cache_miss = 1'b1;
            end
        end
    end

    // Refill FSM: latch the missing line, count beats, publish the line on the last beat.
    // NOTE: sequential state uses non-blocking '<=' so all registers update together.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            word_cnt   <= '0;
            valid      <= '0;
            fill_tag   <= '0;
            fill_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.inv) begin
                        valid <= '0;
                    end
                    if (start_fill) begin
                        fill_tag   <= req_tag;
                        fill_index <= req_index;
                        word_cnt   <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (bus.inv) begin
                        valid    <= '0;
                        word_cnt <= '0;
                        state    <= IDLE;
                    end else if (bus.m_ready) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == '1) begin
                            valid[fill_index] <= 1'b1;
                            state             <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays, written only by refill beats.
    // NOTE: the arrays are deliberately not reset; the valid bits alone decide
    // whether their contents are used, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[{fill_index, word_cnt}] <= bus.m_dout;
        end
        if (last_beat) begin
            tag_mem[fill_index] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating statistics: hits served from the array, refills started.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (array_hit && hit_count != '1) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill && miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_i_cache_line.sv
// Self-checking bench for i_cache_line (default parameters): a directed vector
// table, hand-written invalidate/reset sequences, and randomized traffic
// compared against a line-level behavioural model of the cache.
module tb_i_cache_line;

    logic clk;
    logic clrn;
    logic [31:0] mem_xor;

    i_cache_line_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    i_cache_line dut (
        .clk        (clk),
        .clrn       (clrn),
        .bus        (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a fixed program around 0x100, a pattern elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + {30'b0, a[3:2]};
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.m_dout = mem_fn(bus.m_a) ^ mem_xor;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic s, input logic u,
                         input logic i, input logic r);
        bus.p_a      = a;
        bus.p_strobe = s;
        bus.uncached = u;
        bus.inv      = i;
        bus.m_ready  = r;
    endtask

    task automatic expect_o(input string name, input logic er, input logic [31:0] ed,
                            input logic em, input logic es, input logic [31:0] ema);
        check({name, "/p_ready"}, {31'b0, bus.p_ready}, {31'b0, er});
        if (er) check({name, "/p_din"}, bus.p_din, ed);
        check({name, "/cache_miss"}, {31'b0, bus.cache_miss}, {31'b0, em});
        check({name, "/m_strobe"}, {31'b0, bus.m_strobe}, {31'b0, es});
        check({name, "/m_a"}, bus.m_a, ema);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive after the edge, check mid-cycle, advance to the next edge.
    task automatic step(input string name, input logic [31:0] a, input logic s, input logic u,
                        input logic i, input logic r, input logic er, input logic [31:0] ed,
                        input logic em, input logic es, input logic [31:0] ema);
        drive(a, s, u, i, r);
        #4;
        expect_o(name, er, ed, em, es, ema);
        tick();
    endtask

    task automatic do_reset;
        clrn = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
    endtask

    typedef struct {
        logic [31:0] p_a;
        logic        strobe;
        logic        unc;
        logic        inv;
        logic        mrdy;
        logic        exp_ready;
        logic [31:0] exp_din;
        logic        exp_miss;
        logic        exp_mstb;
        logic [31:0] exp_ma;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] a, input logic s, input logic u, input logic i,
                       input logic r, input logic er, input logic [31:0] ed,
                       input logic em, input logic es, input logic [31:0] ema);
        vec_t v;
        v = '{a, s, u, i, r, er, ed, em, es, ema};
        vq.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    bit          mdl_valid [64];
    logic [21:0] mdl_tag   [64];
    logic [31:0] mdl_data  [64][4];
    bit          mdl_busy;
    logic [31:0] mdl_line_base;
    int          mdl_beats;
    int          mdl_hits;
    int          mdl_misses;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 4) % 64);
    endfunction

    function automatic logic [21:0] tag_of(input logic [31:0] a);
        return 22'(a >> 10);
    endfunction

    function automatic bit mdl_hit(input logic [31:0] a);
        return mdl_valid[idx_of(a)] && (mdl_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic mdl_clear;
        for (int k = 0; k < 64; k++) mdl_valid[k] = 1'b0;
        mdl_busy   = 1'b0;
        mdl_beats  = 0;
        mdl_hits   = 0;
        mdl_misses = 0;
    endtask

    task automatic mdl_expect(output logic er, output logic [31:0] ed, output logic em,
                              output logic es, output logic [31:0] ema);
        er  = 1'b0;
        ed  = 32'h0;
        em  = 1'b0;
        es  = 1'b0;
        ema = bus.p_a;
        if (mdl_busy) begin
            em  = 1'b1;
            es  = 1'b1;
            ema = mdl_line_base + 32'(mdl_beats * 4);
        end else if (bus.p_strobe) begin
            if (bus.uncached) begin
                em = 1'b1;
                es = 1'b1;
                er = bus.m_ready;
                ed = mem_fn(bus.p_a) ^ mem_xor;
            end else if (mdl_hit(bus.p_a)) begin
                er = 1'b1;
                ed = mdl_data[idx_of(bus.p_a)][int'((bus.p_a >> 2) % 4)];
            end else begin
                em = 1'b1;
            end
        end
    endtask

    task automatic mdl_update;
        bit h;
        if (mdl_busy) begin
            if (bus.inv) begin
                for (int k = 0; k < 64; k++) mdl_valid[k] = 1'b0;
                mdl_busy = 1'b0;
            end else if (bus.m_ready) begin
                mdl_data[idx_of(mdl_line_base)][mdl_beats] =
                    mem_fn(mdl_line_base + 32'(mdl_beats * 4)) ^ mem_xor;
                mdl_beats++;
                if (mdl_beats == 4) begin
                    mdl_valid[idx_of(mdl_line_base)] = 1'b1;
                    mdl_tag[idx_of(mdl_line_base)]   = tag_of(mdl_line_base);
                    mdl_busy = 1'b0;
                end
            end
        end else begin
            h = bus.p_strobe && !bus.uncached && mdl_hit(bus.p_a);
            if (h) mdl_hits++;
            if (bus.inv) begin
                for (int k = 0; k < 64; k++) mdl_valid[k] = 1'b0;
            end
            if (bus.p_strobe && !bus.uncached && !h) begin
                mdl_busy      = 1'b1;
                mdl_line_base = {bus.p_a[31:4], 4'b0};
                mdl_beats     = 0;
                mdl_misses++;
            end
        end
    endtask

    initial begin
        logic        er;
        logic [31:0] ed;
        logic        em;
        logic        es;
        logic [31:0] ema;

        mem_xor = 32'h0;
        clrn    = 1'b0;
        drive(32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        // Reset state: idle outputs, m_a follows p_a, nothing valid.
        expect_o("reset_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h1234_5678);
`ifdef ICACHE_STATS_EN
        check("reset_hit_count", hit_count, 32'h0);
        check("reset_miss_count", miss_count, 32'h0);
`endif
        drive(32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        expect_o("reset_cold", 1'b0, 32'h0, 1'b1, 1'b0, 32'h104);
        do_reset();

        // ---------------- directed vector table ----------------
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 0, 32'h104);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h100);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h104);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h108);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h10C);
        add(32'h104,   1, 0, 0, 1, 1, 32'hA1, 0, 0, 32'h104);
        add(32'h100,   1, 0, 0, 1, 1, 32'hA0, 0, 0, 32'h100);
        add(32'h108,   1, 0, 0, 1, 1, 32'hA2, 0, 0, 32'h108);
        add(32'h10C,   1, 0, 0, 1, 1, 32'hA3, 0, 0, 32'h10C);
        add(32'h200,   0, 0, 0, 1, 0, 32'h0,  0, 0, 32'h200);
        add(32'h10104, 1, 0, 0, 1, 0, 32'h0,  1, 0, 32'h10104);
        add(32'h10104, 1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h10100);
        add(32'h10104, 1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h10104);
        add(32'h10104, 1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h10108);
        add(32'h10104, 1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h1010C);
        add(32'h10104, 1, 0, 0, 1, 1, 32'hC0DF_0104, 0, 0, 32'h10104);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 0, 32'h104);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h100);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h104);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h108);
        add(32'h104,   1, 0, 0, 1, 0, 32'h0,  1, 1, 32'h10C);
        add(32'h104,   1, 0, 0, 1, 1, 32'hA1, 0, 0, 32'h104);

        for (int i = 0; i < vq.size(); i++) begin
            step($sformatf("vec%0d", i), vq[i].p_a, vq[i].strobe, vq[i].unc, vq[i].inv,
                 vq[i].mrdy, vq[i].exp_ready, vq[i].exp_din, vq[i].exp_miss,
                 vq[i].exp_mstb, vq[i].exp_ma);
        end
`ifdef ICACHE_STATS_EN
        check("table_hit_count", hit_count, 32'd6);
        check("table_miss_count", miss_count, 32'd3);
`endif

        // ---------------- uncached bypass ----------------
        mem_xor = 32'hFFFF_0000;
        step("unc_stall", 32'h104, 1, 1, 0, 0, 0, 32'h0, 1, 1, 32'h104);
        step("unc_data",  32'h104, 1, 1, 0, 1, 1, 32'hFFFF_00A1, 1, 1, 32'h104);
        step("after_bypass_hit", 32'h104, 1, 0, 0, 1, 1, 32'hA1, 0, 0, 32'h104);
        mem_xor = 32'h0;

        // ---------------- invalidate corner cases ----------------
        step("inv_idle_hit", 32'h104, 1, 0, 1, 0, 1, 32'hA1, 0, 0, 32'h104);
        step("miss_after_inv", 32'h104, 1, 0, 0, 1, 0, 32'h0, 1, 0, 32'h104);
        step("fill_ign_pa0", 32'h300, 1, 0, 0, 1, 0, 32'h0, 1, 1, 32'h100);
        step("fill_ign_pa1", 32'h300, 0, 0, 0, 1, 0, 32'h0, 1, 1, 32'h104);
        step("inv_beat3",    32'h300, 1, 0, 1, 1, 0, 32'h0, 1, 1, 32'h108);
        step("idle_after_abort", 32'h104, 1, 0, 0, 0, 0, 32'h0, 1, 0, 32'h104);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("stall%0d", k), 32'h104, 1, 0, 0, 0, 0, 32'h0, 1, 1, 32'h100);
        end
        step("beat0", 32'h104, 1, 0, 0, 1, 0, 32'h0, 1, 1, 32'h100);
        step("beat1", 32'h104, 1, 0, 0, 1, 0, 32'h0, 1, 1, 32'h104);
        step("beat2", 32'h104, 1, 0, 0, 1, 0, 32'h0, 1, 1, 32'h108);
        step("inv_final_beat", 32'h104, 1, 0, 1, 1, 0, 32'h0, 1, 1, 32'h10C);
        step("line_left_invalid", 32'h104, 1, 0, 0, 0, 0, 32'h0, 1, 0, 32'h104);
        step("refill_beat0", 32'h104, 1, 0, 0, 1, 0, 32'h0, 1, 1, 32'h100);

        // ---------------- clrn in the middle of a refill ----------------
        drive(32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        clrn = 1'b0;
        #1;
        expect_o("clrn_midfill_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
`ifdef ICACHE_STATS_EN
        check("clrn_hit_count", hit_count, 32'h0);
        check("clrn_miss_count", miss_count, 32'h0);
`endif
        drive(32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        expect_o("clrn_midfill_cold", 1'b0, 32'h0, 1'b1, 1'b0, 32'h104);
        tick();
        clrn = 1'b1;
        step("post_reset_miss", 32'h104, 1, 0, 0, 0, 0, 32'h0, 1, 0, 32'h104);

        // ---------------- randomized traffic vs. model ----------------
        do_reset();
        mdl_clear();
        for (int n = 0; n < 800; n++) begin
            drive((32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 3)) << 4)
                      | (32'($urandom_range(0, 3)) << 2),
                  ($urandom % 4) != 0, ($urandom % 10) == 0, ($urandom % 40) == 0,
                  ($urandom % 10) < 7);
            #4;
            mdl_expect(er, ed, em, es, ema);
            expect_o($sformatf("rnd%0d", n), er, ed, em, es, ema);
            mdl_update();
            tick();
        end
`ifdef ICACHE_STATS_EN
        check("rnd_hit_count", hit_count, 32'(mdl_hits));
        check("rnd_miss_count", miss_count, 32'(mdl_misses));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i_cache_line.md
# i_cache_line

Parametrised direct-mapped instruction cache with multi-word lines and a sequential line-refill state machine. It sits between the CPU fetch stage and instruction memory, and is the successor to the single-word-per-block instruction cache. It adds configurable depth and line size, a bypass path for uncached fetches, and a global invalidate. Optional hit/miss statistics counters can be compiled in.

## Interface
- INDEX_BITS, default 6: number of lines is 2^INDEX_BITS.
- OFFSET_BITS, default 2: words per line is 2^OFFSET_BITS (minimum 1, so at least 2 words).
- Derived, not overridable: TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS.
- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- p_a  in  32  CPU fetch address, word aligned; p_a[1:0] is ignored.
- p_strobe  in  1  CPU fetch request.
- uncached  in  1  bypass the cache for this fetch.
- inv  in  1  invalidate all lines (single-cycle pulse).
- p_din  out  32  instruction returned to the CPU.
- p_ready  out  1  p_din is valid this cycle.
- cache_miss  out  1  current request is being served from memory.
- m_a  out  32  memory address.
- m_strobe  out  1  memory read request.
- m_dout  in  32  memory read data.
- m_ready  in  1  memory data valid this cycle.
- hit_count, miss_count  out  32 each  present only with ICACHE_STATS_EN.

## Operation
- Address split: tag = p_a[31:32-TAG_BITS], index = next INDEX_BITS bits, word offset = next OFFSET_BITS bits, then [1:0].
- Storage per line:
  - valid bit, cleared on reset and on inv;
  - tag register;
  - 2^OFFSET_BITS data words, written only by the refill FSM.
- hit = p_strobe & ~uncached & valid[index] & (tag match).
- States: IDLE, FILL.
- IDLE:
  - On hit: p_ready=1 and p_din = data[index][offset], both combinational in the same cycle.
  - Uncached request (p_strobe & uncached): cache_miss=1, m_strobe=1, m_a=p_a, p_ready=m_ready, p_din=m_dout. No array write and no state change.
  - Cached miss: cache_miss=1. On the next edge, latch tag and index, clear the word counter, and go to FILL.
- FILL:
  - m_strobe=1, cache_miss=1, p_ready=0.
  - m_a = {latched tag, latched index, word counter, 2'b00}.
  - Each cycle with m_ready: write m_dout into data[latched index][counter] and increment the counter.
  - When m_ready arrives with counter == 2^OFFSET_BITS-1: write the tag, set valid, return to IDLE. The request then hits on the following cycle.
  - Changes on p_a and p_strobe are ignored while in FILL; the refill always completes as latched.
  - If inv is asserted in FILL: clear all valid bits, abort the refill (no valid set, counter cleared), return to IDLE.
- inv in IDLE: clear all valid bits on the edge. A hit is still reported combinationally in the cycle where inv is high.
- With p_strobe low: p_ready=0, cache_miss=0, m_strobe=0 (except while in FILL).

## Timing
- Reset values:
  - state IDLE, counter 0, all valid bits 0, statistics counters 0;
  - outputs are combinational: m_strobe=0, p_ready=0, cache_miss=0 when p_strobe=0; m_a=p_a.
- Hit latency: 0 cycles (p_ready in the same cycle as p_strobe).
- Miss latency with a zero-wait memory: 1 (IDLE to FILL) + 2^OFFSET_BITS fill beats + 1 hit cycle. With defaults that is 6 cycles from strobe to p_ready.
- Memory handshake: m_a is held stable until m_ready. Memory may stall indefinitely; the FSM waits.
- clrn asserted during FILL: immediate return to IDLE, all valid bits cleared, the partial line is discarded.
- inv and the final fill beat in the same cycle: inv wins, and the line stays invalid.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_count increments on each cycle with a cached hit (p_ready from the array);
  - miss_count increments on each IDLE to FILL transition;
  - both counters saturate at 32'hFFFF_FFFF and reset to 0 on clrn. inv does not clear them.
- ICACHE_STATS_EN undefined: the counters and their ports are absent. All other behaviour is identical.

## Test plan
- Cold miss (defaults): p_a=0x0000_0104, strobe held, memory returns 0xA0,0xA1,0xA2,0xA3 for addresses 0x100..0x10C -> m_a steps 0x100,0x104,0x108,0x10C; p_ready and p_din=0xA1 on the 6th cycle.
- Warm hits: after the cold miss, fetch 0x100, 0x108, 0x10C -> p_ready the same cycle with 0xA0, 0xA2, 0xA3; m_strobe stays 0.
- Conflict: fetch 0x0001_0104 (same index, different tag) -> new refill; a subsequent 0x104 fetch misses again.
- Uncached: uncached=1, p_a=0x104 with a valid line cached -> m_strobe=1, m_a=0x104, p_din=m_dout; the valid bit and data are unchanged.
- Invalidate: inv pulsed during the 3rd fill beat -> FSM returns to IDLE, the next fetch of 0x104 misses; inv coinciding with the final beat -> line left invalid.
- Stats (ICACHE_STATS_EN): cold miss plus 3 hits -> miss_count=1, hit_count=4 (including the post-fill hit); clrn mid-fill -> both counters 0, state IDLE.
